// File: rtl/noc_pkg.sv
// Shared ring-NoC constants and types.
// Flit width, requester count/indices and the VC bit position.
package noc_pkg;

  localparam int DW   = 64;
  localparam int NREQ = 3;
  localparam int VCB  = 63;

  localparam int REQ_CW  = 0;
  localparam int REQ_CCW = 1;
  localparam int REQ_PE  = 2;

  typedef logic [DW-1:0] flit_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first eligible index at or after the pointer.
// Produces a one-hot grant plus the encoded winner index.
module rr_arbiter #(
  parameter int NREQ = noc_pkg::NREQ,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_elig,
  input  logic [PW-1:0]   i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx
);

  logic w_found;
  int   w_j;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = (int'(i_ptr) + k) % NREQ;
      if (i_en && !w_found && i_elig[w_j]) begin
        w_found    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = PW'(w_j);
      end
    end
  end

endmodule

// File: rtl/output_channel_arbiter.sv
// One router output port: fills the internal-phase VC by round-robin
// and drains the external-phase VC onto the send/ready link.
module output_channel_arbiter #(
  parameter int DW   = noc_pkg::DW,
  parameter int NREQ = noc_pkg::NREQ,
  parameter int VCB  = noc_pkg::VCB
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             polarity,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  gnt,
  output logic             so,
  input  logic             ro,
  output logic [DW-1:0]    dout
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [1:0]             r_valid;
  logic [1:0][DW-1:0]     r_data;
  logic [1:0][PW-1:0]     r_ptr;

  logic [1:0][NREQ-1:0]   w_elig;
  logic [1:0][NREQ-1:0]   w_gnt;
  logic [1:0][PW-1:0]     w_idx;
  logic [1:0]             w_en;
  logic [1:0][DW-1:0]     w_win;

  for (genvar v = 0; v < 2; v++) begin : g_vc
    for (genvar i = 0; i < NREQ; i++) begin : g_req
      assign w_elig[v][i] = req[i] &
        (req_data[i*DW+VCB] == 1'(v));
    end

    // Only the internal-phase VC may fill, and only when empty.
    assign w_en[v] = ~reset & (polarity != 1'(v))
                   & ~r_valid[v];

    rr_arbiter #(.NREQ(NREQ)) u_arb (
      .i_elig (w_elig[v]),
      .i_ptr  (r_ptr[v]),
      .i_en   (w_en[v]),
      .o_gnt  (w_gnt[v]),
      .o_idx  (w_idx[v])
    );
  end

  always_comb begin
    w_win = '0;
    for (int v = 0; v < 2; v++)
      for (int i = 0; i < NREQ; i++)
        if (w_gnt[v][i])
          w_win[v] = req_data[i*DW +: DW];
  end

  assign gnt  = w_gnt[0] | w_gnt[1];
  assign so   = r_valid[polarity] & ro;
  assign dout = so ? r_data[polarity] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_data  <= '0;
      r_ptr   <= '0;
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (|w_gnt[v]) begin
          r_valid[v] <= 1'b1;
          r_data[v]  <= w_win[v];
          r_ptr[v]   <= (w_idx[v] == PW'(NREQ-1)) ?
                        '0 : w_idx[v] + PW'(1);
        end else if (so && polarity == 1'(v)) begin
          r_valid[v] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_output_channel_arbiter.sv
// Bench for output_channel_arbiter: directed scenarios plus random
// traffic checked against a slot/pointer reference model.
module tb_output_channel_arbiter;

  localparam int DW = 64;
  localparam int NR = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            polarity = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   gnt;
  logic            so;
  logic            ro = 1'b0;
  logic [DW-1:0]   dout;

  int n_cmp = 0;
  int n_err = 0;

  bit          m_val[2];
  logic [63:0] m_dat[2];
  int          m_ptr[2];
  int          last_win;

  bit          pend[NR];
  logic [63:0] pdat[NR];

  always #5 clk = ~clk;

  output_channel_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .so       (so),
    .ro       (ro),
    .dout     (dout)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with inputs applied; ends after next negedge.
  task automatic step(input string tag);
    int p, iv, w, j;
    bit eso;
    logic [63:0] edo;
    #1;
    p  = int'(polarity);
    iv = 1 - p;
    w  = -1;
    if (!reset && !m_val[iv])
      for (int k = 0; k < NR; k++) begin
        j = (m_ptr[iv] + k) % NR;
        if (w < 0 && req[j] && int'(req_data[j*DW+63]) == iv)
          w = j;
      end
    eso = m_val[p] && ro;
    edo = eso ? m_dat[p] : 64'd0;
    chk({tag, ".gnt"}, 64'(gnt), (w >= 0) ? 64'(1) << w : 64'd0);
    chk({tag, ".so"}, 64'(so), 64'(eso));
    chk({tag, ".dout"}, dout, edo);
    @(posedge clk);
    if (reset) begin
      m_val = '{0, 0};
      m_dat = '{64'd0, 64'd0};
      m_ptr = '{0, 0};
    end else begin
      if (w >= 0) begin
        m_val[iv] = 1'b1;
        m_dat[iv] = req_data[w*DW +: DW];
        m_ptr[iv] = (w + 1) % NR;
      end
      if (eso) m_val[p] = 1'b0;
    end
    last_win = w;
    @(negedge clk);
    polarity = reset ? 1'b0 : ~polarity;
  endtask

  task automatic set_req(input int i, input logic [63:0] f);
    req[i] = 1'b1;
    req_data[i*DW +: DW] = f;
  endtask

  initial begin
    logic [63:0] f;
    m_val = '{0, 0};
    m_dat = '{64'd0, 64'd0};
    m_ptr = '{0, 0};
    @(negedge clk);
    repeat (3) step("rst");
    reset = 1'b0;
    ro = 1'b1;
    repeat (10) step("idle");
    chk("idle.pol", 64'(polarity), 64'd0);

    // Single VC1 flit from requester 2, minimum latency.
    set_req(2, 64'h8000_0000_0000_00AA);
    #1 chk("one.gnt", 64'(gnt), 64'b100);
    step("one.g");
    req = '0;
    #1 chk("one.so", 64'(so), 64'd1);
    chk("one.dout", dout, 64'h8000_0000_0000_00AA);
    step("one.d");
    #1 chk("one.so0", 64'(so), 64'd0);
    step("one.e");

    // Round-robin over three VC0 holders.
    for (int i = 0; i < NR; i++) set_req(i, 64'(i + 1));
    repeat (12) step("rr");
    req = '0;
    repeat (4) step("rr.end");

    // Backpressure on VC0.
    set_req(0, 64'h0000_0000_0000_0055);
    set_req(1, 64'h0000_0000_0000_0066);
    ro = 1'b0;
    repeat (8) begin
      step("bp");
      if (last_win >= 0) req[last_win] = 1'b0;
    end
    ro = 1'b1;
    repeat (6) begin
      step("bp.ro");
      if (last_win >= 0) req[last_win] = 1'b0;
    end

    // Random traffic with occasional reset; holders keep flits until granted.
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    req = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          pdat[i] = {$urandom, $urandom};
        end
        req[i] = pend[i];
        req_data[i*DW +: DW] = pend[i] ? pdat[i]
                              : {$urandom, $urandom};
      end
      ro = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 199) == 0);
      step("rnd");
      if (last_win >= 0) pend[last_win] = 1'b0;
    end
    reset = 1'b0;
    req = '0;
    repeat (4) step("rnd.end");

    // Fill both VCs, then reset and check pointers start over.
    ro = 1'b0;
    if (polarity) step("pre");
    for (int i = 0; i < NR; i++) set_req(i, 64'h8000_0000_0000_0010 + 64'(i));
    step("full1");
    for (int i = 0; i < NR; i++) set_req(i, 64'h0000_0000_0000_0020 + 64'(i));
    step("full0");
    req = '0;
    ro = 1'b1;
    reset = 1'b1;
    step("rst2");
    reset = 1'b0;
    #1 chk("rst2.so", 64'(so), 64'd0);
    chk("rst2.dout", dout, 64'd0);
    for (int i = 0; i < NR; i++) set_req(i, 64'h8000_0000_0000_0030 + 64'(i));
    #1 chk("rst2.gnt", 64'(gnt), 64'b001);
    step("rst2.g");
    req = '0;
    #1 chk("rst2.out", dout, 64'h8000_0000_0000_0030);
    step("rst2.d");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/output_channel_arbiter.md
# output_channel_arbiter

Shares one router output channel (cw, ccw or pe direction) among the router's three input sources and drives the channel's send/ready/data link using the ring's even/odd virtual-channel scheme. It holds one single-flit buffer per virtual channel, fills the internal-phase VC by round-robin arbitration, and drains the external-phase VC to the link. Each router instantiates three of these, one per output port, all driven by the global `polarity` signal.

## Interface
- `DW`, 64, flit width in bits.
- `NREQ`, 3, number of requesters (cw-in, ccw-in, pe-in).
- `VCB`, 63, bit index of the VC field in a flit.

- `clk`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-high.
- `polarity`  in  1  global phase; toggles every cycle after reset, 0 during reset.
- `req`  in  NREQ  requester i holds a flit for this port.
- `req_data`  in  NREQ*DW  flit of requester i, occupying bits [i*DW +: DW]; the VC is bit `VCB` of the flit.
- `gnt`  out  NREQ  one-hot grant, combinational; the flit is taken at the next clk edge.
- `so`  out  1  send-out to the downstream link.
- `ro`  in  1  downstream ready for the external-phase VC.
- `dout`  out  DW  flit to the downstream link.

## Operation
- State:
  - `vbuf[0..1]`: valid bit plus DW data per VC (VC0 = even, VC1 = odd).
  - `ptr[0..1]`: round-robin pointer per VC, range 0..NREQ-1.
- In a cycle with polarity = p:
  - VC p is *external*: it may drain to the link.
  - VC ~p is *internal*: it may be filled from the requesters.
- Fill:
  - Eligible requesters: `req[i]=1` and `req_data[i][VCB] = ~p`.
  - If `vbuf[~p]` is empty and at least one requester is eligible, grant exactly one.
  - The winner is the first eligible index at or after `ptr[~p]`, wrapping NREQ-1 → 0.
  - At the edge: load the winner's flit into `vbuf[~p]`, set valid, set `ptr[~p]` = winner+1 mod NREQ.
  - No grant, and no pointer change, when `vbuf[~p]` is full or nothing is eligible.
  - Requesters whose VC equals p are never granted in that cycle.
- Drain:
  - `so` = `vbuf[p].valid & ro`.
  - `dout` = `vbuf[p].data` when `so`=1, else 0.
  - At the edge where `so`=1, clear `vbuf[p].valid`.
- Fill and drain always target different VCs, so no same-slot conflict is possible in one cycle.
- The flit is passed unmodified; the arbiter never rewrites the VC bit or any other field.
- The VC ~p buffer never drains in phase p, even if `ro`=1.

## Timing
- Reset values:
  - Both buffers invalid, data 0, `ptr[0]=ptr[1]=0`.
  - Outputs: `gnt`=0, `so`=0, `dout`=0.
- `gnt` is purely combinational from `req`, `req_data[VCB]`, `polarity` and state, and is forced to 0 while `reset`=1.
- Minimum latency:
  - Granted in cycle t (polarity ≠ v).
  - Buffered at the end of t.
  - `so`=1 in cycle t+1 (polarity = v) if `ro`=1.
- Backpressure:
  - With `ro`=0 the flit is held.
  - A drain is retried only on later cycles with polarity = v, i.e. every second cycle.
- Throughput: at most one flit per VC per two cycles, so at most one flit per cycle on the link.
- A slot drained at the edge ending cycle t is fillable in cycle t+1, which is its internal phase.
- Reset asserted mid-operation: buffered flits are discarded and all state returns to reset values at that edge.
- Requesters must hold `req` and `req_data` stable until granted; the arbiter does not latch ungranted requests.

## Structure
- Shared package `noc_pkg`:
  - Constants `DW=64`, `NREQ=3`, `VCB=63`.
  - Requester index constants `REQ_CW=0`, `REQ_CCW=1`, `REQ_PE=2`.
  - Typedef `flit_t` (logic [DW-1:0]).
- Sub-module `rr_arbiter`:
  - Parameter NREQ.
  - Inputs: eligible mask, pointer, enable.
  - Outputs: one-hot grant, winner index.
  - Instantiated once per VC.

## Test plan
- Reset, then idle 10 cycles with `req`=0 and `ro`=1 → `gnt`, `so`, `dout` stay 0 throughout.
- Polarity=0, requester 2 sends flit 0x8000_0000_0000_00AA (VC1), `ro`=1 → `gnt`=3'b100 that cycle; next cycle (polarity=1) `so`=1 and `dout`=0x8000_0000_0000_00AA; the cycle after, `so`=0.
- All three requesters hold VC0 flits 0x…01, 0x…02, 0x…03 continuously, `ro`=1 → grants in order 0, 1, 2, 0 on the odd-polarity cycles; `dout` sequence is 01, 02, 03 on even-polarity cycles.
- VC0 flit buffered with `ro`=0 for 6 cycles → `so` stays 0 and no further VC0 grants occur; `ro` rises → `so`=1 on the first following polarity-0 cycle, then the buffer refills on the next cycle.
- Requester 0 sends VC0 and requester 1 sends VC1 simultaneously → each is granted only in its own VC's internal phase; `so` pulses on consecutive cycles with the two flits interleaved.
- Reset asserted while both VC buffers are full → `so`=0 and `dout`=0 after the edge; `ptr` returns to 0; the first post-reset grant goes to requester 0 when all requesters are eligible.
